// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio datapath types and default constants
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    SHIFT,
    DONE
  } serializer_state_t;

  localparam int SAMPLE_WIDTH = 16;
  localparam int SERIAL_DIV   = 4;
  localparam int MEM_READ_LAT = 2;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_serializer_if.sv
// rtl/sample_serializer_if.sv - playback request / DAC serial link bundle
interface sample_serializer_if import audio_pkg::*; #(
  parameter int DATA_WIDTH = SAMPLE_WIDTH
);

  logic                  play;
  logic [DATA_WIDTH-1:0] memData;
  logic                  serialClock;
  logic                  serialData;
  logic                  frameSync;
  logic                  sDone;
  logic                  busy;

  modport master (
    input  play, memData,
    output serialClock, serialData, frameSync, sDone, busy
  );

  modport slave (
    output play, memData,
    input  serialClock, serialData, frameSync, sDone, busy
  );

endinterface

// File: rtl/serial_clock_gen.sv
// rtl/serial_clock_gen.sv - bit-period divider producing serialClock and bitTick
module serial_clock_gen import audio_pkg::*; #(
  parameter int DIV = SERIAL_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic shift_next,
  output logic serialClock,
  output logic bitTick
);

  localparam int            CW   = min1_clog2(2 * DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV);

  logic [CW-1:0] div_q, div_d;
  logic          serialClock_q, serialClock_d;

  // serialClock is registered from next-cycle values so it lines up with the divider.
  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (enable) begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end
    serialClock_d = shift_next && (div_d >= HALF);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      serialClock_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      serialClock_q <= serialClock_d;
    end
  end

  assign bitTick     = enable && (div_q == LAST);
  assign serialClock = serialClock_q;

endmodule

// File: rtl/sample_serializer.sv
// rtl/sample_serializer.sv - loads a playback sample and shifts it MSB-first to the DAC
module sample_serializer import audio_pkg::*; #(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int DIV        = SERIAL_DIV,
  parameter int READ_LAT   = MEM_READ_LAT
) (
  input logic                 clock,
  input logic                 reset,
  sample_serializer_if.master bus
);

  localparam int BW = min1_clog2(DATA_WIDTH);
  localparam int WW = min1_clog2(READ_LAT);

  serializer_state_t     state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  serialData_q, serialData_d;
  logic                  frameSync_q, frameSync_d;
  logic                  sDone_q, sDone_d;
  logic                  busy_q, busy_d;
  logic                  bit_tick;
  logic                  in_load, in_shift, shift_next;

  assign in_load    = (state_q == LOAD);
  assign in_shift   = (state_q == SHIFT);
  assign shift_next = (state_d == SHIFT);

  serial_clock_gen #(.DIV(DIV)) u_clock_gen (
    .clock       (clock),
    .reset       (reset),
    .clear       (in_load),
    .enable      (in_shift),
    .shift_next  (shift_next),
    .serialClock (bus.serialClock),
    .bitTick     (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (bus.play) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      end
      WAIT: begin
        if (wait_q == WW'(READ_LAT - 1)) state_d = LOAD;
        else                             wait_d  = wait_q + 1'b1;
      end
      LOAD: begin
        shreg_d = bus.memData;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_tick) begin
          shreg_d = shreg_q << 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DONE: begin
        wait_d  = '0;
        state_d = bus.play ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they align with the state they describe.
    serialData_d = shift_next && shreg_d[DATA_WIDTH-1];
    frameSync_d  = shift_next && (bit_d == '0);
    sDone_d      = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      serialData_q <= 1'b0;
      frameSync_q  <= 1'b0;
      sDone_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      serialData_q <= serialData_d;
      frameSync_q  <= frameSync_d;
      sDone_q      <= sDone_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.serialData = serialData_q;
  assign bus.frameSync  = frameSync_q;
  assign bus.sDone      = sDone_q;
  assign bus.busy       = busy_q;

endmodule
